truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential stimulus-and-capture stage for the small combinational Boolean blocks (SoP/PoS forms of 3-input functions). It is the neighbour on both sides of the function under test: it drives the function inputs row by row, samples the function output after a settle window, and builds the full truth table. It then compares the table against an expected vector and reports the match result, the first mismatching row and the maxterm count. It replaces the hand-written `#1` input sweeps with a synthesizable, handshaked scanner.

## Interface
- `N_IN`, default 3 — number of function inputs; the table has 2**N_IN rows.
- `SETTLE`, default 1 — cycles each row is held before sampling; legal range ≥ 0.

- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst_n` in 1 — reset is synchronous and active-low.
- `start` in 1 — request a scan; accepted only in IDLE.
- `expected` in 2**N_IN — expected truth table; bit i is the required output for input row i; latched when `start` is accepted.
- `f_in` in 1 — output of the function under test.
- `x_out` out N_IN — drives the function inputs; MSB is X, LSB is Z for N_IN=3.
- `busy` out 1 — high while a scan is in progress (SCAN state).
- `done` out 1 — one-cycle pulse when results are valid.
- `table_out` out 2**N_IN — captured truth table; bit i is `f_in` sampled for row i.
- `match` out 1 — `table_out == expected_latched`.
- `mismatch_idx` out N_IN — lowest row index where the table differs from `expected`; 0 when `match`=1.
- `maxterm_cnt` out N_IN+1 — number of zero rows in `table_out`, range 0..2**N_IN.

## Operation
- Reset value (while `rst_n`=0 at an edge): state IDLE; every output is 0; row and phase counters are 0; latched expected is 0.
- States:
  - **IDLE**: `start`=1 moves to SCAN. On that transition, latch `expected`, clear `table_out`, `match`, `mismatch_idx` and `maxterm_cnt`, and set row=0, phase=0.
  - **SCAN**: `x_out` = row. `phase` counts 0..SETTLE. When phase==SETTLE:
    - write `f_in` into `table_out[row]`;
    - if row == 2**N_IN−1, move to DONE; otherwise row++ and phase=0.
  - **DONE**: assert `done` for this cycle only. `match`, `mismatch_idx` and `maxterm_cnt` become valid here, computed combinationally from the complete table and registered. Return to IDLE next cycle.
- `start` is ignored in SCAN and DONE. It is not queued.
- `x_out` returns to 0 on entering IDLE.
- Results hold their values until the next accepted `start`.
- Width rules:
  - row counter is N_IN bits and never wraps mid-scan;
  - phase counter is width clog2(SETTLE+1), minimum 1 bit;
  - `maxterm_cnt` is N_IN+1 bits, so an all-zero table reports 2**N_IN without overflow.
- Reset mid-scan aborts immediately: every output returns to its reset value on that edge, and no `done` is produced.

## Timing
- Each row takes SETTLE+1 cycles. `f_in` is sampled on the edge that ends the row's last phase, so a combinational DUT has at least SETTLE+1 cycles of settling.
- With `start` sampled high at edge 0:
  - `busy` is high from edge 0 to edge 2**N_IN·(SETTLE+1);
  - `done` is high in the following cycle, i.e. after edge 2**N_IN·(SETTLE+1)+1 − 1.
- Defaults (N_IN=3, SETTLE=1): 16 scan cycles; `done` is high in cycle 17 after start acceptance.
- When `start` is held high continuously, scans repeat back to back with exactly one IDLE cycle between `done` and the next `busy`. The repeat period is 2**N_IN·(SETTLE+1)+2 cycles, which is 18 at the defaults.

## Structure
- Package `truth_scan_pkg` holds:
  - the state enum (IDLE, SCAN, DONE);
  - default constants for N_IN and SETTLE;
  - a popcount-of-zeros function used for `maxterm_cnt`;
  - a first-set-bit function used for `mismatch_idx`.
- One sub-module, `scan_row_counter`, holds the row and phase counters and their enable, clear and last-row flags. The top level holds the FSM, the table register and the result registers.

## Test plan
- DUT f = ~X | (~Y & ~Z) (zeros at rows 5, 6, 7), `expected`=8'h1F → `table_out`=8'h1F, `match`=1, `mismatch_idx`=0, `maxterm_cnt`=3. `done` pulses exactly in cycle 17 after start acceptance, and `x_out` steps 0..7, each value held 2 cycles.
- Same DUT, `expected`=8'h1E → `match`=0, `mismatch_idx`=0, `table_out`=8'h1F, `maxterm_cnt`=3.
- `f_in` tied to 0, `expected`=8'h00 → `table_out`=0, `match`=1, `maxterm_cnt`=4'd8 (no overflow).
- `rst_n` pulled low while row=3 → on that edge all outputs are 0 and no `done` appears. A fresh `start` then completes normally with correct results.
- `start` pulsed again mid-scan → ignored; a single `done` occurs at the original time. `start` held high → `done` pulses every 18 cycles.
- Parameter run with SETTLE=0 → each row takes 1 cycle and `done` is high in cycle 9; results match the first scenario.

Source files
------------

// File: rtl/truth_scan_pkg.sv
// Shared types, defaults and table-reduction helpers for the truth table scanner.
package truth_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 1;

    // Helpers work on a fixed maximum table width; callers zero-extend.
    localparam int MAX_N_IN = 8;
    localparam int MAX_ROWS = 1 << MAX_N_IN;

    function automatic int count_zeros(input logic [MAX_ROWS-1:0] v, input int rows);
        int n;
        n = 0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            if ((i < rows) && !v[i]) n++;
        end
        return n;
    endfunction

    // Lowest set bit index, 0 when no bit is set.
    function automatic int first_set(input logic [MAX_ROWS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_ROWS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/truth_table_scanner_row_counter.sv
// Row/phase counters for the scanner: each row is held SETTLE+1 cycles, row stops at the last index.
module scan_row_counter
    import truth_scan_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            en_i,
    output logic [N_IN-1:0] row_o,
    output logic            sample_o,
    output logic            row_last_o
);

    localparam int PW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE);

    logic [PW-1:0]   phase_q, phase_d;
    logic [N_IN-1:0] row_q, row_d;

    assign row_o      = row_q;
    assign sample_o   = (phase_q == PHASE_LAST);
    assign row_last_o = (row_q == {N_IN{1'b1}});

    always_comb begin
        row_d   = row_q;
        phase_d = phase_q;
        if (clear_i) begin
            row_d   = '0;
            phase_d = '0;
        end else if (en_i) begin
            if (sample_o) begin
                phase_d = '0;
                // Last row holds so the index never wraps before the FSM leaves SCAN.
                if (!row_last_o) row_d = row_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q   <= '0;
            phase_q <= '0;
        end else begin
            row_q   <= row_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives a combinational function row by row, captures its truth table and grades it against an expected vector.
// Handshake: start is accepted only in IDLE; done is a one-cycle pulse and results stay valid until the next accepted start.
module truth_table_scanner
    import truth_scan_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      x_out,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] table_out,
    output logic                 match,
    output logic [N_IN-1:0]      mismatch_idx,
    output logic [N_IN:0]        maxterm_cnt,
    output logic [1:0]           state_dbg
);

    localparam int ROWS = 1 << N_IN;

    scan_state_t     state_q, state_d;
    logic [ROWS-1:0] table_q, table_d;
    logic [ROWS-1:0] exp_q, exp_d;
    logic            match_q, match_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   cnt_q, cnt_d;

    logic            cnt_clear, cnt_en, sample, row_last;
    logic [N_IN-1:0] row;

    scan_row_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_row_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (cnt_clear),
        .en_i       (cnt_en),
        .row_o      (row),
        .sample_o   (sample),
        .row_last_o (row_last)
    );

    always_comb begin
        state_d   = state_q;
        table_d   = table_q;
        exp_d     = exp_q;
        match_d   = match_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    exp_d     = expected;
                    table_d   = '0;
                    match_d   = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    cnt_clear = 1'b1;
                end
            end
            ST_SCAN: begin
                cnt_en = 1'b1;
                if (sample) begin
                    table_d[row] = f_in;
                    // Grade the table including the row captured on this edge so results are valid in DONE.
                    if (row_last) begin
                        state_d = ST_DONE;
                        match_d = (table_d == exp_q);
                        idx_d   = N_IN'(first_set(MAX_ROWS'(table_d ^ exp_q)));
                        cnt_d   = (N_IN+1)'(count_zeros(MAX_ROWS'(table_d), ROWS));
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            table_q <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q == ST_SCAN);
    assign done         = (state_q == ST_DONE);
    assign x_out        = busy ? row : '0;
    assign table_out    = table_q;
    assign match        = match_q;
    assign mismatch_idx = idx_q;
    assign maxterm_cnt  = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a SETTLE=1 and a SETTLE=0 instance scanning f = ~X | (~Y & ~Z) or a constant 0.
module tb_truth_table_scanner;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start;
    logic [1:0][7:0] exp_in;
    logic [1:0]      f_in;
    logic            fmode;
    wire  [1:0][2:0] x_o;
    wire  [1:0]      busy_o;
    wire  [1:0]      done_o;
    wire  [1:0][7:0] tbl_o;
    wire  [1:0]      match_o;
    wire  [1:0][2:0] idx_o;
    wire  [1:0][3:0] cnt_o;
    wire  [1:0][1:0] dbg_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed result: {table[7:0], match, idx[2:0], cnt[3:0]}
    logic [15:0] exp_q[$];

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .expected(exp_in[0]), .f_in(f_in[0]),
        .x_out(x_o[0]), .busy(busy_o[0]), .done(done_o[0]), .table_out(tbl_o[0]),
        .match(match_o[0]), .mismatch_idx(idx_o[0]), .maxterm_cnt(cnt_o[0]), .state_dbg(dbg_o[0])
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .expected(exp_in[1]), .f_in(f_in[1]),
        .x_out(x_o[1]), .busy(busy_o[1]), .done(done_o[1]), .table_out(tbl_o[1]),
        .match(match_o[1]), .mismatch_idx(idx_o[1]), .maxterm_cnt(cnt_o[1]), .state_dbg(dbg_o[1])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fref(input logic [2:0] x);
        return ~x[2] | (~x[1] & ~x[0]);
    endfunction

    always_comb begin
        f_in = '0;
        for (int i = 0; i < 2; i++) f_in[i] = fmode ? fref(x_o[i]) : 1'b0;
    end

    function automatic logic [15:0] model(input logic [7:0] e, input logic fm);
        logic [7:0] tbl;
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       found;
        tbl = '0; idx = '0; cnt = '0; found = 1'b0;
        for (int r = 0; r < 8; r++) tbl[r] = fm ? fref(3'(r)) : 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (!tbl[r]) cnt = cnt + 4'd1;
            if (!found && (tbl[r] != e[r])) begin
                idx   = 3'(r);
                found = 1'b1;
            end
        end
        return {tbl, (tbl == e), idx, cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero_outputs(input int sel, input string tag);
        check({tag, "_x"},     32'(x_o[sel]), 0);
        check({tag, "_busy"},  32'(busy_o[sel]), 0);
        check({tag, "_done"},  32'(done_o[sel]), 0);
        check({tag, "_res"},   32'({tbl_o[sel], match_o[sel], idx_o[sel], cnt_o[sel]}), 0);
        check({tag, "_state"}, 32'(dbg_o[sel]), 0);
    endtask

    // Driver: one scan, scoreboard push at start, pop/compare at done.
    task automatic run_scan(input int sel, input logic [7:0] expv, input logic fm, input int pulse_at);
        int         s, lat, cyc;
        bit         seen;
        logic [15:0] want;
        s   = (sel == 0) ? 1 : 0;
        lat = 8 * (s + 1) + 1;
        @(negedge clk);
        fmode       = fm;
        exp_in[sel] = expv;
        start[sel]  = 1'b1;
        exp_q.push_back(model(expv, fm));
        @(posedge clk);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start[sel] = (cyc == pulse_at);
            if (done_o[sel]) begin
                seen = 1;
            end else if (cyc <= 8 * (s + 1)) begin
                check("busy_scan", 32'(busy_o[sel]), 1);
                check("x_out_step", 32'(x_o[sel]), 32'((cyc - 1) / (s + 1)));
            end
        end
        start[sel] = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("done_cycle", 32'(cyc), 32'(lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("state_done", 32'(dbg_o[sel]), 2);
        check("results", 32'({tbl_o[sel], match_o[sel], idx_o[sel], cnt_o[sel]}), 32'(want));
        @(negedge clk);
        check("done_single", 32'(done_o[sel]), 0);
        check("idle_busy", 32'(busy_o[sel]), 0);
        check("idle_x", 32'(x_o[sel]), 0);
        check("hold_results", 32'({tbl_o[sel], match_o[sel], idx_o[sel], cnt_o[sel]}), 32'(want));
        @(negedge clk);
        check("no_requeue", 32'(busy_o[sel]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, npulse, ndone;
        logic [15:0] want;
        rst_n  = 1'b0;
        start  = '0;
        exp_in = '0;
        fmode  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs(0, "reset0");
        check_zero_outputs(1, "reset1");
        rst_n = 1'b1;

        // Matching, mismatching and all-zero tables
        run_scan(0, 8'h1F, 1'b1, 0);
        run_scan(0, 8'h1E, 1'b1, 0);
        run_scan(0, 8'h3F, 1'b1, 0);
        run_scan(0, 8'h00, 1'b0, 0);
        run_scan(0, 8'hA5, 1'b0, 0);

        // Start pulse mid-scan is ignored
        run_scan(0, 8'h1F, 1'b1, 5);

        // Start held high: back-to-back scans every 18 cycles
        @(negedge clk);
        fmode     = 1'b1;
        exp_in[0] = 8'h1F;
        start[0]  = 1'b1;
        repeat (3) exp_q.push_back(model(8'h1F, 1'b1));
        @(posedge clk);
        cyc = 0;
        npulse = 0;
        while (npulse < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc == 18) check("hold_gap_idle", 32'(busy_o[0]), 0);
            if (cyc == 19) check("hold_gap_busy", 32'(busy_o[0]), 1);
            if (done_o[0]) begin
                npulse++;
                check("hold_done_cycle", 32'(cyc), 32'(17 + 18 * (npulse - 1)));
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("hold_results", 32'({tbl_o[0], match_o[0], idx_o[0], cnt_o[0]}), 32'(want));
                if (npulse == 3) start[0] = 1'b0;
            end
        end
        check("hold_pulses", 32'(npulse), 3);
        repeat (2) @(negedge clk);
        check("hold_stop", 32'(busy_o[0]), 0);

        // Reset mid-scan at row 3 aborts with no done
        @(negedge clk);
        exp_in[0] = 8'h1F;
        start[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (x_o[0] != 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_row3", 32'(x_o[0]), 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs(0, "abort");
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        check("abort_no_done", 32'(ndone), 0);
        run_scan(0, 8'h1F, 1'b1, 0);

        // SETTLE=0 instance
        run_scan(1, 8'h1F, 1'b1, 0);
        run_scan(1, 8'h00, 1'b0, 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
